// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite responder holding a flat register file: NUM_CTRL read/write
// control words (word indices 0..NUM_CTRL-1) followed by NUM_STS read-only
// status words (indices NUM_CTRL..NUM_CTRL+NUM_STS-1). Word index = ADDR[31:2].
// Write and read channels are independent, each with one transaction in flight.
//
// Optional feature macro: AXI_LITE_SLV_ERR_EN
//   defined   : out-of-range reads and writes to status/out-of-range indices
//               respond SLVERR (2'b10)
//   undefined : the same accesses respond OKAY (2'b00); data behaviour is
//               identical (reads return 0, writes are dropped)
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   AW*/W*/B*                write address, write data, write response
//   AR*/R*                   read address, read data/response
//   ctrl_regs [NUM_CTRL*32]  control register k on bits [32k+31:32k]
//   sts_in    [NUM_STS*32]   status word j on bits [32j+31:32j]
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int NUM_CTRL = 8,
    parameter int NUM_STS  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [31:0]             AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [31:0]             ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [NUM_CTRL*32-1:0]  ctrl_regs,
    input  logic [NUM_STS*32-1:0]   sts_in
);

    localparam int         NUM_WORDS   = NUM_CTRL + NUM_STS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef AXI_LITE_SLV_ERR_EN
    localparam logic [1:0] RESP_ERR    = 2'b10;
`else
    localparam logic [1:0] RESP_ERR    = 2'b00;
`endif

    // Byte-offset bits do not take part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    // Low through reset and the first edge after it, so no handshake can
    // happen on that first edge.
    logic        rdy_en_q;

    logic        aw_held_q;
    logic [29:0] aw_idx_q;
    logic        w_held_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        wr_is_ctrl;
    logic [29:0] ar_idx;
    logic [31:0] rd_data_d;
    logic [1:0]  rd_resp_d;

    assign AWREADY = rdy_en_q && !aw_held_q && !bvalid_q;
    assign WREADY  = rdy_en_q && !w_held_q  && !bvalid_q;
    assign ARREADY = rdy_en_q && !rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs      = AWVALID && AWREADY;
    assign w_hs       = WVALID && WREADY;
    assign ar_hs      = ARVALID && ARREADY;
    assign commit     = aw_held_q && w_held_q && !bvalid_q;
    assign wr_is_ctrl = (aw_idx_q < 30'(NUM_CTRL));
    assign ar_idx     = ARADDR[31:2];

    // Control registers: one block per word, byte lanes gated by the strobe.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
            logic [31:0] reg_q;
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    reg_q <= '0;
                end else if (commit && aw_idx_q == 30'(gi)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) begin
                            reg_q[8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
            assign ctrl_regs[32*gi +: 32] = reg_q;
        end
    endgenerate

    // Read source mux. Control words come from the current register outputs,
    // so a read landing on the same edge as a commit sees the old value.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (ar_idx == 30'(k)) begin
                rd_data_d = ctrl_regs[32*k +: 32];
            end
        end
        for (int j = 0; j < NUM_STS; j++) begin
            if (ar_idx == 30'(NUM_CTRL + j)) begin
                rd_data_d = sts_in[32*j +: 32];
            end
        end
        if (ar_idx >= 30'(NUM_WORDS)) begin
            rd_resp_d = RESP_ERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rdy_en_q <= 1'b1;

            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= AWADDR[31:2];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end

            // Commit and a new accept can never coincide: accepts need the
            // hold flag clear, commit needs both set.
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_is_ctrl ? RESP_OKAY : RESP_ERR;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_d;
                rresp_q  <= rd_resp_d;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
module tb_axi_lite_reg_slave;

    logic         ACLK;
    logic         ARESETn;
    logic [31:0]  AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [255:0] ctrl_regs;
    logic [127:0] sts_in;

`ifdef AXI_LITE_SLV_ERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-maintained expected image of the control register file.
    logic [255:0] exp_ctrl;

    axi_lite_reg_slave #(.NUM_CTRL(8), .NUM_STS(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ctrl_regs(ctrl_regs), .sts_in(sts_in)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge ACLK);
    endtask

    // Full write: both beats offered together, waits for the response.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int  n;
        bit  awd, wd;
        AWADDR = a; AWVALID = 1'b1;
        WDATA  = d; WSTRB = s; WVALID = 1'b1;
        BREADY = 1'b1;
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 20) begin
            if (AWVALID && AWREADY) awd = 1;
            if (WVALID && WREADY) wd = 1;
            cyc(); n++;
            if (awd) AWVALID = 1'b0;
            if (wd)  WVALID  = 1'b0;
        end
        n = 0;
        while (!BVALID && n < 20) begin
            cyc(); n++;
        end
        chk("write_bvalid_seen", 256'(BVALID), 256'(1));
        resp = BRESP;
        cyc();
        BREADY = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0;
        $display("write addr=%h data=%h strb=%b bresp=%b", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin
            cyc(); n++;
        end
        cyc();
        ARVALID = 1'b0;
        chk("read_rvalid_seen", 256'(RVALID), 256'(1));
        d = RDATA; resp = RRESP;
        cyc();
        RREADY = 1'b0;
        $display("read  addr=%h rdata=%h rresp=%b", a, d, resp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          pulses;

        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARVALID = 0; RREADY = 0;
        sts_in = {32'hA5A5_0003, 32'h0000_0002, 32'h0000_0001, 32'hCAFE_0001};
        exp_ctrl = '0;

        // ---- reset state ----
        repeat (3) cyc();
        chk("rst_ready", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
        chk("rst_valid", 256'({BVALID, RVALID}), 256'(0));
        chk("rst_resp_data", 256'({BRESP, RRESP, RDATA}), 256'(0));
        chk("rst_ctrl", ctrl_regs, 256'(0));
        ARESETn = 1'b1;
        chk("ready_before_first_edge", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
        cyc();
        chk("ready_after_first_edge", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));
        $display("reset released");

        // ---- write 0xDEADBEEF to 0x04, AW and W together ----
        AWADDR = 32'h04; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
        BREADY = 1;
        cyc();                                  // handshake edge k
        AWVALID = 0; WVALID = 0;
        chk("t1_no_bvalid_yet", 256'(BVALID), 256'(0));
        chk("t1_awready_held", 256'(AWREADY), 256'(0));
        cyc();                                  // commit edge k+1
        exp_ctrl[63:32] = 32'hDEADBEEF;
        chk("t1_bvalid", 256'(BVALID), 256'(1));
        chk("t1_bresp", 256'(BRESP), 256'(2'b00));
        chk("t1_ctrl", ctrl_regs, exp_ctrl);
        cyc();                                  // B handshake
        chk("t1_bvalid_clear", 256'(BVALID), 256'(0));
        chk("t1_ready_back", 256'({AWREADY, WREADY}), 256'(2'b11));
        BREADY = 0;
        $display("write addr=00000004 data=deadbeef bresp=00");

        ARADDR = 32'h04; ARVALID = 1; RREADY = 1;
        chk("t1_arready", 256'(ARREADY), 256'(1));
        cyc();
        ARVALID = 0;
        chk("t1_rvalid", 256'(RVALID), 256'(1));
        chk("t1_rdata", 256'(RDATA), 256'(32'hDEADBEEF));
        chk("t1_rresp", 256'(RRESP), 256'(2'b00));
        cyc();
        chk("t1_rvalid_clear", 256'(RVALID), 256'(0));
        RREADY = 0;
        $display("read  addr=00000004 rdata=deadbeef");

        // ---- W three cycles before AW, strobe 0101 ----
        pulses = 0;
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1; BREADY = 1;
        cyc();
        WVALID = 0;
        chk("t2_wready_held", 256'(WREADY), 256'(0));
        for (int i = 0; i < 2; i++) begin
            if (BVALID) pulses++;
            cyc();
        end
        if (BVALID) pulses++;
        AWADDR = 32'h00; AWVALID = 1;
        cyc();
        AWVALID = 0;
        if (BVALID) pulses++;
        cyc();
        exp_ctrl[31:0] = 32'h00220044;
        chk("t2_bvalid", 256'(BVALID), 256'(1));
        chk("t2_ctrl", ctrl_regs, exp_ctrl);
        for (int i = 0; i < 5; i++) begin
            if (BVALID) pulses++;
            cyc();
        end
        chk("t2_one_pulse", 256'(pulses), 256'(1));
        BREADY = 0;
        $display("write addr=00000000 data=11223344 strb=0101 pulses=%0d", pulses);

        // ---- backpressure: B and R held 5 cycles ----
        AWADDR = 32'h08; AWVALID = 1; WDATA = 32'h5; WSTRB = 4'hF; WVALID = 1;
        ARADDR = 32'h04; ARVALID = 1;
        chk("t3_readies_idle", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));
        cyc();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        cyc();
        exp_ctrl[95:64] = 32'h5;
        for (int i = 0; i < 5; i++) begin
            chk("t3_b_hold", 256'({BVALID, BRESP}), 256'(3'b100));
            chk("t3_r_hold", 256'({RVALID, RRESP, RDATA}), 256'({1'b1, 2'b00, 32'hDEADBEEF}));
            chk("t3_readies_low", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
            cyc();
        end
        chk("t3_ctrl", ctrl_regs, exp_ctrl);
        BREADY = 1; RREADY = 1;
        cyc();
        chk("t3_released", 256'({BVALID, RVALID}), 256'(0));
        chk("t3_readies_back", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));
        BREADY = 0; RREADY = 0;
        $display("stall write 0x08=5 and read 0x04 released");

        // ---- read and commit to 0x08 on the same edge ----
        AWADDR = 32'h08; AWVALID = 1; WDATA = 32'h9; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
        cyc();
        AWVALID = 0; WVALID = 0;
        ARADDR = 32'h08; ARVALID = 1; RREADY = 1;
        chk("t4_arready", 256'(ARREADY), 256'(1));
        chk("t4_bvalid_pre", 256'(BVALID), 256'(0));
        cyc();
        ARVALID = 0;
        exp_ctrl[95:64] = 32'h9;
        chk("t4_rdata_old", 256'({RVALID, RDATA}), 256'({1'b1, 32'h5}));
        chk("t4_bvalid", 256'(BVALID), 256'(1));
        chk("t4_ctrl", ctrl_regs, exp_ctrl);
        cyc();
        chk("t4_both_done", 256'({BVALID, RVALID}), 256'(0));
        BREADY = 0; RREADY = 0;
        $display("collide read 0x08 returned old=5");
        axi_read(32'h08, rd, rs);
        chk("t4_rdata_new", 256'(rd), 256'(32'h9));

        // ---- status, out-of-range, strobe zero, low address bits ----
        axi_read(32'h20, rd, rs);
        chk("sts0_data", 256'(rd), 256'(32'hCAFE0001));
        chk("sts0_resp", 256'(rs), 256'(2'b00));
        axi_read(32'h2C, rd, rs);
        chk("sts3_data", 256'(rd), 256'(32'hA5A50003));
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, rs);
        chk("wr_sts_resp", 256'(rs), 256'(EXP_ERR));
        chk("wr_sts_dropped", ctrl_regs, exp_ctrl);
        axi_read(32'h40, rd, rs);
        chk("oor_rd_data", 256'(rd), 256'(0));
        chk("oor_rd_resp", 256'(rs), 256'(EXP_ERR));
        axi_read(32'h30, rd, rs);
        chk("oor_first_resp", 256'({rd, rs}), 256'({32'h0, EXP_ERR}));
        axi_write(32'h40, 32'h12345678, 4'hF, rs);
        chk("wr_oor_resp", 256'(rs), 256'(EXP_ERR));
        chk("wr_oor_dropped", ctrl_regs, exp_ctrl);
        axi_write(32'h04, 32'h0, 4'b0000, rs);
        chk("strb0_resp", 256'(rs), 256'(2'b00));
        chk("strb0_nochange", ctrl_regs, exp_ctrl);
        axi_write(32'h1F, 32'h0BADF00D, 4'b1100, rs);
        exp_ctrl[255:224] = 32'h0BAD0000;
        chk("last_ctrl_resp", 256'(rs), 256'(2'b00));
        chk("last_ctrl", ctrl_regs, exp_ctrl);
        axi_read(32'h1D, rd, rs);
        chk("last_ctrl_rd", 256'({rd, rs}), 256'({32'h0BAD0000, 2'b00}));

        // ---- reset between AW and W ----
        AWADDR = 32'h0C; AWVALID = 1;
        cyc();
        AWVALID = 0;
        chk("t6_aw_held", 256'({AWREADY, WREADY}), 256'(2'b01));
        ARESETn = 0;
        #1;
        exp_ctrl = '0;
        chk("t6_rst_ctrl", ctrl_regs, exp_ctrl);
        chk("t6_rst_out", 256'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 256'(0));
        cyc();
        ARESETn = 1;
        cyc();
        WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
        chk("t6_wready", 256'(WREADY), 256'(1));
        cyc();
        WVALID = 0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (BVALID) pulses++;
            cyc();
        end
        chk("t6_no_bvalid", 256'(pulses), 256'(0));
        chk("t6_ctrl_zero", ctrl_regs, exp_ctrl);
        BREADY = 0;
        $display("reset mid-write: lone W produced %0d responses", pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
